// File: rtl/alu_dec_unit.sv
// ---------------------------------------------------------------------------
// alu_dec_unit
//   Lab datapath block for the NPC board top:
//     * 4-bit two's-complement ALU with zero / overflow / carry flags
//     * 3-bit wrap-around down counter advanced by an external tick strobe
//     * 3-to-8 one-hot decoder with enable
//
//   Build option:
//     ALU_OUT_REG_EN  - when defined, the ALU result and flags are registered
//                       on clk (one cycle of latency, cleared by resetn).
//                       When undefined, the ALU is purely combinational.
//   The counter and the decoder behave identically in both builds.
// ---------------------------------------------------------------------------
module alu_dec_unit (
    input  logic       clk,
    input  logic       resetn,

    // ALU
    input  logic [2:0] alu_fnselec,
    input  logic [3:0] alu_a,
    input  logic [3:0] alu_b,
    output logic [3:0] alu_res,
    output logic       alu_zero,
    output logic       alu_overflow,
    output logic       alu_carry,

    // Down counter
    input  logic       counter_en,
    input  logic       tick,
    output logic [2:0] dec_counter_out,

    // Decoder
    input  logic [2:0] dec_x,
    input  logic       dec_en,
    output logic [7:0] dec_y
);

    // ALU function encoding as driven on alu_fnselec.
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_NOT = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_SLT = 3'b110,
        OP_EQ  = 3'b111
    } alu_op_e;

    alu_op_e    alu_op;
    assign alu_op = alu_op_e'(alu_fnselec);

    // -----------------------------------------------------------------------
    // ALU datapath
    // -----------------------------------------------------------------------
    // Adder and subtractor are both always computed: slt reuses the
    // subtractor's sign and overflow to form a correct signed compare.
    logic [4:0] add_full;
    logic [4:0] sub_full;
    logic       add_ovf;
    logic       sub_ovf;
    logic       slt_less;

    assign add_full = {1'b0, alu_a} + {1'b0, alu_b};
    // Subtract as A + ~B + 1 so carry-out reads as "no borrow".
    assign sub_full = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;

    assign add_ovf  = (alu_a[3] == alu_b[3]) && (add_full[3] != alu_a[3]);
    assign sub_ovf  = (alu_a[3] != alu_b[3]) && (sub_full[3] != alu_a[3]);
    assign slt_less = sub_full[3] ^ sub_ovf;

    logic [3:0] res_d;
    logic       zero_d;
    logic       ovf_d;
    logic       carry_d;

    // Select the ALU result and flags for the current function.
    always_comb begin
        // NOTE: every output of this block is given a default first so no
        // path through the case leaves a signal unassigned (no latch).
        res_d   = 4'b0000;
        ovf_d   = 1'b0;
        carry_d = 1'b0;
        unique case (alu_op)
            OP_ADD: begin
                res_d   = add_full[3:0];
                carry_d = add_full[4];
                ovf_d   = add_ovf;
            end
            OP_SUB: begin
                res_d   = sub_full[3:0];
                carry_d = sub_full[4];
                ovf_d   = sub_ovf;
            end
            OP_NOT: res_d = ~alu_a;
            OP_AND: res_d = alu_a & alu_b;
            OP_OR:  res_d = alu_a | alu_b;
            OP_XOR: res_d = alu_a ^ alu_b;
            OP_SLT: res_d = {3'b000, slt_less};
            OP_EQ:  res_d = {3'b000, (alu_a == alu_b)};
            default: res_d = 4'b0000;
        endcase
    end

    // Zero flag follows the final result for every function.
    assign zero_d = (res_d == 4'b0000);

`ifdef ALU_OUT_REG_EN
    logic [3:0] alu_res_q;
    logic       alu_zero_q;
    logic       alu_overflow_q;
    logic       alu_carry_q;

    // Register the ALU result and flags; cleared while resetn is low.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            alu_res_q      <= 4'b0000;
            alu_zero_q     <= 1'b0;
            alu_overflow_q <= 1'b0;
            alu_carry_q    <= 1'b0;
        end else begin
            alu_res_q      <= res_d;
            alu_zero_q     <= zero_d;
            alu_overflow_q <= ovf_d;
            alu_carry_q    <= carry_d;
        end
    end

    assign alu_res      = alu_res_q;
    assign alu_zero     = alu_zero_q;
    assign alu_overflow = alu_overflow_q;
    assign alu_carry    = alu_carry_q;
`else
    assign alu_res      = res_d;
    assign alu_zero     = zero_d;
    assign alu_overflow = ovf_d;
    assign alu_carry    = carry_d;
`endif

    // -----------------------------------------------------------------------
    // Down counter
    // -----------------------------------------------------------------------
    logic [2:0] cnt_q;
    logic [2:0] cnt_d;

    // Decrement (wrapping 0 -> 7) only when a tick arrives while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (counter_en && tick) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    // Counter state register; reset forces 0 immediately, dropping any tick.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!resetn) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign dec_counter_out = cnt_q;

    // -----------------------------------------------------------------------
    // 3-to-8 one-hot decoder
    // -----------------------------------------------------------------------
    assign dec_y = dec_en ? (8'h01 << dec_x) : 8'h00;

endmodule

// File: tb/tb_alu_dec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_dec_unit
//   Directed, self-checking bench for alu_dec_unit. Expected values are
//   hand-computed constants. Works for both builds: with ALU_OUT_REG_EN the
//   ALU outputs are sampled one clock after the operands are applied.
// ---------------------------------------------------------------------------
module tb_alu_dec_unit;

    logic       clk;
    logic       resetn;
    logic [2:0] alu_fnselec;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_res;
    logic       alu_zero;
    logic       alu_overflow;
    logic       alu_carry;
    logic       counter_en;
    logic       tick;
    logic [2:0] dec_counter_out;
    logic [2:0] dec_x;
    logic       dec_en;
    logic [7:0] dec_y;

    int total = 0;
    int bad   = 0;

    alu_dec_unit dut (
        .clk             (clk),
        .resetn          (resetn),
        .alu_fnselec     (alu_fnselec),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_res         (alu_res),
        .alu_zero        (alu_zero),
        .alu_overflow    (alu_overflow),
        .alu_carry       (alu_carry),
        .counter_en      (counter_en),
        .tick            (tick),
        .dec_counter_out (dec_counter_out),
        .dec_x           (dec_x),
        .dec_en          (dec_en),
        .dec_y           (dec_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply operands and check {res, zero, overflow, carry}.
    task automatic alu_step(input string tag, input logic [2:0] fn,
                            input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] res, input logic z,
                            input logic ovf, input logic cy);
        alu_fnselec = fn;
        alu_a       = a;
        alu_b       = b;
`ifdef ALU_OUT_REG_EN
        @(posedge clk);
`endif
        #1;
        check(tag, {1'b0, alu_res, alu_zero, alu_overflow, alu_carry},
                   {1'b0, res, z, ovf, cy});
    endtask

    // One tick-qualified cycle, then sample the counter just after the edge.
    task automatic tick_step(input string tag, input logic en, input logic [2:0] exp);
        @(negedge clk);
        counter_en = en;
        tick       = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        check(tag, {5'b0, dec_counter_out}, {5'b0, exp});
    endtask

    initial begin
        logic [2:0] seq [9];
        seq = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};

        resetn      = 1'b0;
        alu_fnselec = 3'b000;
        alu_a       = 4'b0000;
        alu_b       = 4'b0000;
        counter_en  = 1'b0;
        tick        = 1'b0;
        dec_x       = 3'd0;
        dec_en      = 1'b0;

        // Reset state
        #2;
        check("rst_counter", {5'b0, dec_counter_out}, 8'h00);
        check("rst_dec_y", dec_y, 8'h00);
`ifdef ALU_OUT_REG_EN
        check("rst_alu", {1'b0, alu_res, alu_zero, alu_overflow, alu_carry}, 8'h00);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;

        // ALU add
        alu_step("add_ovf",  3'b000, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1, 1'b0);
        alu_step("add_wrap", 3'b000, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1);
        // ALU sub / compare
        alu_step("sub_borrow", 3'b001, 4'b0011, 4'b0101, 4'b1110, 1'b0, 1'b0, 1'b0);
        alu_step("slt_3_5",    3'b110, 4'b0011, 4'b0101, 4'b0001, 1'b0, 1'b0, 1'b0);
        alu_step("sub_ovf",    3'b001, 4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b1, 1'b1);
        alu_step("slt_m8_1",   3'b110, 4'b1000, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0);
        alu_step("slt_5_3",    3'b110, 4'b0101, 4'b0011, 4'b0000, 1'b1, 1'b0, 1'b0);
        alu_step("sub_equal",  3'b001, 4'b0110, 4'b0110, 4'b0000, 1'b1, 1'b0, 1'b1);
        alu_step("eq_true",    3'b111, 4'b1010, 4'b1010, 4'b0001, 1'b0, 1'b0, 1'b0);
        alu_step("eq_false",   3'b111, 4'b1010, 4'b1011, 4'b0000, 1'b1, 1'b0, 1'b0);
        // ALU logic ops
        alu_step("not", 3'b010, 4'b1100, 4'b1010, 4'b0011, 1'b0, 1'b0, 1'b0);
        alu_step("and", 3'b011, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b0, 1'b0);
        alu_step("or",  3'b100, 4'b1100, 4'b1010, 4'b1110, 1'b0, 1'b0, 1'b0);
        alu_step("xor", 3'b101, 4'b1100, 4'b1010, 4'b0110, 1'b0, 1'b0, 1'b0);
        alu_step("not_zero", 3'b010, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);

        // Counter: nine enabled ticks, then a disabled tick
        for (int i = 0; i < 9; i++) begin
            tick_step($sformatf("cnt_tick%0d", i), 1'b1, seq[i]);
        end
        tick_step("cnt_no_en", 1'b0, 3'd7);
        // Counter without tick holds
        @(negedge clk);
        counter_en = 1'b1;
        @(posedge clk);
        #1;
        check("cnt_no_tick", {5'b0, dec_counter_out}, 8'h07);

        // Tick held high for two cycles gives two decrements: 7 -> 5
        @(negedge clk);
        tick = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tick = 1'b0;
        check("cnt_held2", {5'b0, dec_counter_out}, 8'h05);

        // Async reset between edges at value 5, with a tick pending
        @(negedge clk);
        tick = 1'b1;
        #1;
        resetn = 1'b0;
        #1;
        check("cnt_async_rst", {5'b0, dec_counter_out}, 8'h00);
        @(posedge clk);
        #1;
        check("cnt_rst_held", {5'b0, dec_counter_out}, 8'h00);
        @(negedge clk);
        tick       = 1'b0;
        resetn     = 1'b1;
        tick_step("cnt_after_rst", 1'b1, 3'd7);

        // Decoder
        dec_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] exp_y;
            exp_y = 8'h01 << i;
            dec_x = 3'(i);
            #1;
            check($sformatf("dec_x%0d", i), dec_y, exp_y);
        end
        dec_en = 1'b0;
        dec_x  = 3'd3;
        #1;
        check("dec_disabled", dec_y, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
